// File: rtl/spi_pkg.sv
// Shared constants and sizing helpers for the SPI register-bank peripheral.
package spi_pkg;

  localparam logic SPI_RD = 1'b0;
  localparam logic SPI_WR = 1'b1;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with registered rise/fall pulses
// taken from the last two stages.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W register file, CIPO read-back
// and write commit on nCS rise after a frame-length check.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = clog2(FRAME_W + 2);
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;

  logic sclk_s, sclk_rise_p, sclk_fall_p;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] copi_q;
  logic copi_s;

  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0]  shadow_q;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q, strobe_c;
  logic frame_err_q, cipo_q, cipo_oe_q, in_frame_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .sync_o(sclk_s), .rise_o(sclk_rise_p), .fall_o(sclk_fall_p)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(nCS),
    .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) copi_q <= '0;
    else        copi_q <= {copi_q[SYNC_STAGES-2:0], COPI};
  end
  assign copi_s = copi_q[SYNC_STAGES-1];

  // Frame field decode: committed frame from shift_q, read address from the incoming shift.
  logic              rw_bit, addr_ok, rd_ok, rd_hit, active, sclk_rise, sclk_fall;
  logic [ADDR_W-1:0] addr_f, rd_addr;
  logic [DATA_W-1:0] data_f;

  assign shift_d   = {shift_q[FRAME_W-2:0], copi_s};
  assign rw_bit    = shift_q[FRAME_W-1];
  assign addr_f    = shift_q[DATA_W +: ADDR_W];
  assign data_f    = shift_q[DATA_W-1:0];
  assign addr_ok   = {1'b0, addr_f} < (ADDR_W+1)'(NUM_REGS);
  assign rd_addr   = shift_d[ADDR_W-1:0];
  assign rd_ok     = {1'b0, rd_addr} < (ADDR_W+1)'(NUM_REGS);
  assign rd_hit    = (cnt_q == CNT_W'(ADDR_W)) && (shift_d[ADDR_W] == SPI_RD);
  assign active    = in_frame_q & ~cs_s & ~cs_fall & ~cs_rise;
  assign sclk_rise = sclk_rise_p & sclk_s;
  assign sclk_fall = sclk_fall_p & ~sclk_s;

  always_comb begin
    strobe_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) strobe_c[i] = (addr_f == ADDR_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      shadow_q    <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      in_frame_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      cipo_oe_q   <= (in_frame_q | cs_fall) & ~cs_rise;
      if (cs_fall) begin
        in_frame_q <= 1'b1;
        cnt_q      <= '0;
        shift_q    <= '0;
        shadow_q   <= '0;
        cipo_q     <= 1'b0;
      end else if (cs_rise && in_frame_q) begin
        in_frame_q <= 1'b0;
        if (cnt_q != CNT_W'(FRAME_W)) begin
          frame_err_q <= 1'b1;
        end else if (rw_bit == SPI_WR && addr_ok) begin
          regs_q[IDX_W'(addr_f)] <= data_f;
          wr_strobe_q            <= strobe_c;
        end
      end else if (active) begin
        if (sclk_rise) begin
          // Bits past the frame end only park the counter in the overflow state.
          if (cnt_q < CNT_W'(FRAME_W)) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= CNT_W'(FRAME_W + 1);
          end
          if (rd_hit) shadow_q <= rd_ok ? regs_q[IDX_W'(rd_addr)] : '0;
        end
        if (sclk_fall) begin
          cipo_q   <= shadow_q[DATA_W-1];
          shadow_q <= shadow_q << 1;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: expected strobe/error events are queued as
// frames are driven and matched by a monitor as the DUT produces them.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n, SCLK, nCS, COPI;
  logic        CIPO, cipo_oe, frame_err;
  logic [63:0] regs_flat;
  logic [7:0]  wr_strobe;

  typedef struct {
    bit          is_err;
    int          addr;
    logic [7:0]  data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mon_s;
  logic [7:0] model [8];
  int         checks = 0;
  int         errors = 0;
  int         writes_seen = 0;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(nCS), .COPI(COPI),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wr_strobe !== 8'h00 || frame_err !== 1'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event strobe=%h frame_err=%b", wr_strobe, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = mon_e.is_err ? 8'h00 : 8'h01 << mon_e.addr;
        if (wr_strobe !== mon_s || frame_err !== mon_e.is_err ||
            (!mon_e.is_err && regs_flat[mon_e.addr*8 +: 8] !== mon_e.data)) begin
          errors++;
          $display("FAIL scoreboard_event strobe=%h err=%b reg=%h expected strobe=%h err=%b reg=%h",
                   wr_strobe, frame_err, regs_flat[mon_e.addr*8 +: 8], mon_s, mon_e.is_err, mon_e.data);
        end
        if (!mon_e.is_err) writes_seen++;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  // Drives one frame LSB-justified in 'frame', MSB first; returns CIPO bits 9..16.
  task automatic spi_xfer(input logic [31:0] frame, input int nbits, output logic [7:0] rd);
    rd  = 8'h00;
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      int k;
      k    = nbits - 1 - i;
      COPI = frame[i];
      repeat (4) @(negedge clk);
      if (k >= 8 && k < 16) rd = {rd[6:0], CIPO};
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    nCS = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (regs_flat !== 64'h0 || wr_strobe !== 8'h00 || frame_err !== 1'b0 ||
        CIPO !== 1'b0 || cipo_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs regs=%h strobe=%h err=%b cipo=%b oe=%b expected all zero",
               regs_flat, wr_strobe, frame_err, CIPO, cipo_oe);
    end
    rst_n = 1'b1;
    settle();
    checks++;
    if (exp_q.size() != 0 || regs_flat !== 64'h0) begin
      errors++;
      $display("FAIL reset_release pending=%0d regs=%h expected 0 and 0", exp_q.size(), regs_flat);
    end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    exp_q.push_back('{is_err: 1'b0, addr: 0, data: 8'hA5});
    model[0] = 8'hA5;
    spi_xfer(32'h80A5, 16, rd);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_strobe !== 8'h00) begin
      errors++;
      $display("FAIL write_latency_early strobe=%h expected 00", wr_strobe);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_strobe !== 8'h01 || regs_flat[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL write_latency strobe=%h reg0=%h expected 01 A5", wr_strobe, regs_flat[7:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_strobe !== 8'h00) begin
      errors++;
      $display("FAIL write_strobe_width strobe=%h expected 00", wr_strobe);
    end
    settle();
  endtask

  task automatic test_read();
    logic [7:0] rd;
    exp_q.push_back('{is_err: 1'b0, addr: 3, data: 8'h3C});
    model[3] = 8'h3C;
    spi_xfer(32'h833C, 16, rd);
    settle();
    spi_xfer(32'h0300, 16, rd);
    settle();
    checks++;
    if (rd !== 8'h3C) begin
      errors++;
      $display("FAIL read_reg3 cipo=%h expected 3C", rd);
    end
    checks++;
    if (regs_flat[31:24] !== 8'h3C || exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_side_effect reg3=%h pending=%0d expected 3C 0", regs_flat[31:24], exp_q.size());
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] rd;
    exp_q.push_back('{is_err: 1'b1, addr: 0, data: 8'h00});
    spi_xfer(32'h81A, 12, rd);
    settle();
    exp_q.push_back('{is_err: 1'b1, addr: 0, data: 8'h00});
    spi_xfer(32'h811AA, 20, rd);
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_err_pulses pending=%0d expected 0", exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs_flat[i*8 +: 8] !== model[i]) begin
        errors++;
        $display("FAIL frame_err_regs reg%0d=%h expected %h", i, regs_flat[i*8 +: 8], model[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    spi_xfer(32'hFF12, 16, rd);
    settle();
    spi_xfer(32'h1000, 16, rd);
    settle();
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL read_oob cipo=%h expected 00", rd);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs_flat[i*8 +: 8] !== model[i]) begin
        errors++;
        $display("FAIL write_oob_regs reg%0d=%h expected %h", i, regs_flat[i*8 +: 8], model[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] frame;
    logic [7:0]  rd;
    frame = 16'h825A;
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 7; i--) begin
      COPI = frame[i];
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    checks++;
    if (cipo_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_oe oe=%b expected 1", cipo_oe);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (regs_flat !== 64'h0 || wr_strobe !== 8'h00 || frame_err !== 1'b0 ||
        CIPO !== 1'b0 || cipo_oe !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs regs=%h strobe=%h err=%b cipo=%b oe=%b expected all zero",
               regs_flat, wr_strobe, frame_err, CIPO, cipo_oe);
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    rst_n = 1'b1;
    nCS   = 1'b1;
    settle();
    exp_q.push_back('{is_err: 1'b0, addr: 2, data: 8'h5A});
    model[2] = 8'h5A;
    spi_xfer(32'h825A, 16, rd);
    settle();
    checks++;
    if (regs_flat[23:16] !== 8'h5A || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_write reg2=%h pending=%0d expected 5A 0", regs_flat[23:16], exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int         base;
    base = writes_seen;
    exp_q.push_back('{is_err: 1'b0, addr: 4, data: 8'hFF});
    spi_xfer(32'h84FF, 16, rd);
    repeat (8) @(negedge clk);
    exp_q.push_back('{is_err: 1'b0, addr: 4, data: 8'h00});
    model[4] = 8'h00;
    spi_xfer(32'h8400, 16, rd);
    settle();
    checks++;
    if (writes_seen - base != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_strobes count=%0d pending=%0d expected 2 0", writes_seen - base, exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs_flat[i*8 +: 8] !== model[i]) begin
        errors++;
        $display("FAIL final_regs reg%0d=%h expected %h", i, regs_flat[i*8 +: 8], model[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    SCLK  = 1'b0;
    nCS   = 1'b1;
    COPI  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_frame_err();
    test_out_of_range();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
